// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES block loader
// Purpose : FSM state encoding, block geometry, PKCS#7 constants and a
//           byte-slot write helper used by block_loader and pkcs7_pad.
// Ports   : none (package)
package aes_pkg;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    ISSUE,
    WAIT
  } state_t;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [7:0] PKCS7_FULL  = 8'h10;

  typedef logic [127:0] block_t;

  // Slot 0 is the first byte of the block and lives in the top byte lane.
  function automatic block_t set_slot(block_t blk, logic [3:0] slot, logic [7:0] value);
    block_t r;
    r = blk;
    r[127 - 8*int'(slot) -: 8] = value;
    return r;
  endfunction

endpackage

// File: rtl/pkcs7_pad.sv
// rtl/pkcs7_pad.sv - combinational PKCS#7 padding of a partial block
// Purpose : given a block whose last data byte sits in slot i_last_idx (0..14),
//           fill slots i_last_idx+1..15 with the PKCS#7 value 15-i_last_idx.
// Ports   : i_block    [127:0] packed block, slot 0 in [127:120]
//           i_last_idx [3:0]   slot index of the final message byte
//           o_block    [127:0] padded block
module pkcs7_pad
  import aes_pkg::*;
(
  input  logic [127:0] i_block,
  input  logic [3:0]   i_last_idx,
  output logic [127:0] o_block
);

  logic [7:0] w_pad_val;

  // Number of pad bytes equals 16-(n+1), which is also the byte value.
  assign w_pad_val = {4'd0, 4'd15 - i_last_idx};

  always_comb begin
    o_block = i_block;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (k > int'(i_last_idx)) begin
        o_block[127 - 8*k -: 8] = w_pad_val;
      end
    end
  end

endmodule

// File: rtl/block_loader.sv
// rtl/block_loader.sv - byte stream to 128-bit block packer feeding the AES encryptor
// Purpose : packs bytes into 16-byte blocks with PKCS#7 padding on the final
//           block, holds the key, pulses o_enc_start once per block and waits
//           for i_enc_done before packing the next block.
// Config  : CBC_CHAIN_EN defined -> CBC chaining (adds i_iv_in, i_ciphertext_in);
//           undefined -> ECB.
// Ports   : i_clk, i_rst (sync, active-high)
//           i_key_in[127:0], i_key_load     key capture (FILL, byte count 0 only)
//           i_in_data[7:0], i_in_valid, i_in_last, o_in_ready   byte stream
//           o_plaintext[127:0], o_key[127:0], o_enc_start, i_enc_done  encryptor side
//           o_busy, o_blk_count[CNT_W-1:0], o_timeout_err       status
//           i_iv_in[127:0], i_ciphertext_in[127:0]              CBC only
module block_loader
  import aes_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [127:0]       i_key_in,
  input  logic               i_key_load,
  input  logic [7:0]         i_in_data,
  input  logic               i_in_valid,
  input  logic               i_in_last,
  output logic               o_in_ready,
  output logic [127:0]       o_plaintext,
  output logic [127:0]       o_key,
  output logic               o_enc_start,
  input  logic               i_enc_done,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_blk_count,
`ifdef CBC_CHAIN_EN
  input  logic [127:0]       i_iv_in,
  input  logic [127:0]       i_ciphertext_in,
`endif
  output logic               o_timeout_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_count;
  logic [3:0]         r_last_idx;
  logic [127:0]       r_block;
  logic               r_pad_pending;
  logic [127:0]       r_key;
  logic [CNT_W-1:0]   r_blk_count;
  logic               r_timeout_err;
  logic [TMO_W-1:0]   r_wait_cnt;
  logic               r_in_ready;
  logic [127:0]       w_padded;
  logic               w_accept;
  logic               w_key_take;
  logic               w_done_take;
  logic               w_timeout;
`ifdef CBC_CHAIN_EN
  logic [127:0]       r_chain;
`endif

  pkcs7_pad u_pad (
    .i_block    (r_block),
    .i_last_idx (r_last_idx),
    .o_block    (w_padded)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_key_take   = 1'b0;
    w_done_take  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      FILL: begin
        w_accept   = i_in_valid && r_in_ready;
        w_key_take = i_key_load && (r_count == 4'd0);
        if (w_accept) begin
          if (r_count == 4'd15) begin
            w_next_state = ISSUE;
          end else if (i_in_last) begin
            w_next_state = PAD;
          end
        end
      end
      PAD:   w_next_state = ISSUE;
      ISSUE: w_next_state = WAIT;
      WAIT: begin
        // First WAIT cycle still sees done left high by the previous block.
        if ((r_wait_cnt != '0) && i_enc_done) begin
          w_done_take  = 1'b1;
          w_next_state = r_pad_pending ? ISSUE : FILL;
        end else if (r_wait_cnt == TMO_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= FILL;
      r_count       <= 4'd0;
      r_last_idx    <= 4'd0;
      r_block       <= '0;
      r_pad_pending <= 1'b0;
      r_key         <= '0;
      r_blk_count   <= '0;
      r_timeout_err <= 1'b0;
      r_wait_cnt    <= '0;
      r_in_ready    <= 1'b0;
`ifdef CBC_CHAIN_EN
      r_chain       <= '0;
`endif
    end else begin
      r_state    <= w_next_state;
      // Registered so it stays low during the first cycle after reset release.
      r_in_ready <= (w_next_state == FILL);

      if (w_key_take) begin
        r_key         <= i_key_in;
        r_blk_count   <= '0;
        r_timeout_err <= 1'b0;
`ifdef CBC_CHAIN_EN
        r_chain       <= i_iv_in;
`endif
      end

      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_block <= set_slot(r_block, r_count, i_in_data);
            r_count <= r_count + 4'd1;
            if (r_count == 4'd15) begin
              // A message ending exactly on a block boundary needs a full pad block.
              r_pad_pending <= i_in_last;
            end else begin
              r_last_idx <= r_count;
            end
          end
        end
        PAD: begin
          r_block <= w_padded;
        end
        ISSUE: begin
          r_blk_count <= r_blk_count + CNT_W'(1);
          r_wait_cnt  <= '0;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + TMO_W'(1);
          if (w_done_take) begin
`ifdef CBC_CHAIN_EN
            r_chain <= i_ciphertext_in;
`endif
            if (r_pad_pending) begin
              r_block       <= {BLOCK_BYTES{PKCS7_FULL}};
              r_pad_pending <= 1'b0;
            end else begin
              r_count <= 4'd0;
            end
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_count       <= 4'd0;
            r_pad_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready    = r_in_ready;
`ifdef CBC_CHAIN_EN
  assign o_plaintext   = r_block ^ r_chain;
`else
  assign o_plaintext   = r_block;
`endif
  assign o_key         = r_key;
  assign o_enc_start   = (r_state == ISSUE);
  assign o_busy        = (r_state != FILL);
  assign o_blk_count   = r_blk_count;
  assign o_timeout_err = r_timeout_err;

endmodule
